lfsr_way_scheduler: RTL and testbench

Victim-way scheduler for set-associative caches and other N-way resource pools. It accepts one replacement request at a time, over a valid/ready handshake, with per-way valid and lock masks. It returns one victim way in one-hot and binary form. Selection order: first free way (invalid and unlocked); otherwise a pseudo-random start index from an internal 16-bit LFSR, followed by a round-robin scan past locked ways. It sits between a cache miss handler and the tag/data array write port.

---
 rtl/lfsr_way_scheduler.sv | 150 +++++++++++++++
 tb/tb_lfsr_way_scheduler.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/lfsr_way_scheduler.sv
// Victim-way scheduler: first free way, otherwise an LFSR-seeded round-robin
// scan past locked ways. One request in flight; registered response outputs.
module lfsr_way_scheduler #(
  parameter int unsigned NumWays = 8,
  parameter logic [15:0] Seed    = 16'h0000,
  localparam int unsigned LogWays = $clog2(NumWays)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               flush_i,
  input  logic               req_valid_i,
  output logic               req_ready_o,
  input  logic [NumWays-1:0] valid_ways_i,
  input  logic [NumWays-1:0] lock_ways_i,
  output logic               rsp_valid_o,
  input  logic               rsp_ready_i,
  output logic [NumWays-1:0] rsp_way_oh_o,
  output logic [LogWays-1:0] rsp_way_bin_o,
  output logic               rsp_none_o,
  output logic               busy_o
);

  typedef enum logic [1:0] {
    IDLE,
    SEARCH,
    RESP
  } state_e;

  state_e               state_q, state_d;
  logic [15:0]          lfsr_q, lfsr_d;
  logic [NumWays-1:0]   cand_q, cand_d;
  logic [LogWays-1:0]   idx_q, idx_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [NumWays-1:0]   rsp_oh_q, rsp_oh_d;
  logic [LogWays-1:0]   rsp_bin_q, rsp_bin_d;
  logic                 rsp_none_q, rsp_none_d;

  logic [15:0]          lfsr_adv;
  logic [NumWays-1:0]   free_w;
  logic [NumWays-1:0]   cand_w;
  logic                 free_hit;
  logic [LogWays-1:0]   free_idx;

  always_comb begin
    state_d     = state_q;
    lfsr_d      = lfsr_q;
    cand_d      = cand_q;
    idx_d       = idx_q;
    rsp_valid_d = rsp_valid_q;
    rsp_oh_d    = rsp_oh_q;
    rsp_bin_d   = rsp_bin_q;
    rsp_none_d  = rsp_none_q;

    lfsr_adv = {lfsr_q[14:0], ~(lfsr_q[15] ^ lfsr_q[12] ^ lfsr_q[5] ^ lfsr_q[1])};
    cand_w   = ~lock_ways_i;
    free_w   = ~valid_ways_i & ~lock_ways_i;

    free_hit = 1'b0;
    free_idx = '0;
    for (int unsigned i = 0; i < NumWays; i++) begin
      if (free_w[i] && !free_hit) begin
        free_hit = 1'b1;
        free_idx = LogWays'(i);
      end
    end

    unique case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          cand_d = cand_w;
          if (cand_w == '0) begin
            rsp_none_d  = 1'b1;
            rsp_oh_d    = '0;
            rsp_bin_d   = '0;
            rsp_valid_d = 1'b1;
            state_d     = RESP;
          end else if (free_hit) begin
            rsp_none_d  = 1'b0;
            rsp_oh_d    = NumWays'(1) << free_idx;
            rsp_bin_d   = free_idx;
            rsp_valid_d = 1'b1;
            state_d     = RESP;
          end else begin
            idx_d   = lfsr_q[LogWays-1:0];
            state_d = SEARCH;
          end
        end
      end
      SEARCH: begin
        // Index wraps naturally since NumWays is a power of two.
        if (cand_q[idx_q]) begin
          rsp_none_d  = 1'b0;
          rsp_oh_d    = NumWays'(1) << idx_q;
          rsp_bin_d   = idx_q;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else begin
          idx_d = idx_q + LogWays'(1);
        end
      end
      RESP: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          lfsr_d      = lfsr_adv;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (flush_i) begin
      state_d     = IDLE;
      lfsr_d      = Seed;
      rsp_valid_d = 1'b0;
      rsp_oh_d    = '0;
      rsp_bin_d   = '0;
      rsp_none_d  = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      lfsr_q      <= Seed;
      cand_q      <= '0;
      idx_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_oh_q    <= '0;
      rsp_bin_q   <= '0;
      rsp_none_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      cand_q      <= cand_d;
      idx_q       <= idx_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_oh_q    <= rsp_oh_d;
      rsp_bin_q   <= rsp_bin_d;
      rsp_none_q  <= rsp_none_d;
    end
  end

  assign req_ready_o   = (state_q == IDLE);
  assign busy_o        = (state_q != IDLE);
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_way_oh_o  = rsp_oh_q;
  assign rsp_way_bin_o = rsp_bin_q;
  assign rsp_none_o    = rsp_none_q;

endmodule

// File: tb/tb_lfsr_way_scheduler.sv
// Randomized self-checking bench for lfsr_way_scheduler (8 ways, seed 0)
// against a transaction-level reference model.
module tb_lfsr_way_scheduler;
  localparam int NW = 8;

  logic       clk = 1'b0;
  logic       rst_i = 1'b1;
  logic       flush_i = 1'b0;
  logic       req_valid_i = 1'b0;
  logic       req_ready_o;
  logic [7:0] valid_ways_i = '0;
  logic [7:0] lock_ways_i = '0;
  logic       rsp_valid_o;
  logic       rsp_ready_i = 1'b0;
  logic [7:0] rsp_way_oh_o;
  logic [2:0] rsp_way_bin_o;
  logic       rsp_none_o;
  logic       busy_o;

  int checks = 0;
  int failures = 0;
  int m_lfsr = 0;

  lfsr_way_scheduler #(.NumWays(8), .Seed(16'h0000)) dut (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .valid_ways_i(valid_ways_i), .lock_ways_i(lock_ways_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_way_oh_o(rsp_way_oh_o), .rsp_way_bin_o(rsp_way_bin_o),
    .rsp_none_o(rsp_none_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int lfsr_next(input int x);
    int fb;
    fb = 1 - (((x >> 15) + (x >> 12) + (x >> 5) + (x >> 1)) & 1);
    return ((x * 2) % 65536) + fb;
  endfunction

  task automatic do_reset();
    rst_i = 1'b1;
    step();
    step();
    chk("rst_ready", int'(req_ready_o), 1);
    chk("rst_valid", int'(rsp_valid_o), 0);
    chk("rst_oh", int'(rsp_way_oh_o), 0);
    chk("rst_bin", int'(rsp_way_bin_o), 0);
    chk("rst_none", int'(rsp_none_o), 0);
    chk("rst_busy", int'(busy_o), 0);
    rst_i = 1'b0;
    m_lfsr = 0;
  endtask

  // One full transaction: accept, wait for response, stall `hold` cycles, handshake.
  task automatic do_req(input logic [7:0] v, input logic [7:0] l, input int hold);
    logic [7:0] free;
    int e_way, e_lat, e_none, s, k, lat;
    free = ~v & ~l;
    e_way = 0; e_none = 0;
    if (l == 8'hFF) begin
      e_none = 1; e_lat = 1;
    end else if (free != 0) begin
      for (int i = NW - 1; i >= 0; i--) if (free[i]) e_way = i;
      e_lat = 1;
    end else begin
      s = m_lfsr % NW;
      k = 0;
      while (l[(s + k) % NW]) k++;
      e_way = (s + k) % NW;
      e_lat = 2 + k;
    end

    chk("ready_idle", int'(req_ready_o), 1);
    req_valid_i = 1'b1; valid_ways_i = v; lock_ways_i = l;
    step();
    req_valid_i = 1'b0;
    valid_ways_i = 8'($urandom); lock_ways_i = 8'($urandom);
    lat = 1;
    while (!rsp_valid_o && lat < NW + 4) begin
      chk("busy_wait", int'(busy_o), 1);
      chk("ready_wait", int'(req_ready_o), 0);
      step();
      lat++;
    end
    chk("latency", lat, e_lat);
    chk("rsp_valid", int'(rsp_valid_o), 1);
    chk("rsp_oh", int'(rsp_way_oh_o), e_none ? 0 : (1 << e_way));
    chk("rsp_bin", int'(rsp_way_bin_o), e_way);
    chk("rsp_none", int'(rsp_none_o), e_none);
    chk("busy_resp", int'(busy_o), 1);
    for (int h = 0; h < hold; h++) begin
      step();
      valid_ways_i = 8'($urandom); lock_ways_i = 8'($urandom);
      chk("hold_valid", int'(rsp_valid_o), 1);
      chk("hold_oh", int'(rsp_way_oh_o), e_none ? 0 : (1 << e_way));
      chk("hold_bin", int'(rsp_way_bin_o), e_way);
      chk("hold_none", int'(rsp_none_o), e_none);
      chk("hold_ready", int'(req_ready_o), 0);
    end
    rsp_ready_i = 1'b1;
    step();
    rsp_ready_i = 1'b0;
    chk("post_valid", int'(rsp_valid_o), 0);
    chk("post_ready", int'(req_ready_o), 1);
    chk("post_busy", int'(busy_o), 0);
    m_lfsr = lfsr_next(m_lfsr);
  endtask

  initial begin
    do_reset();
    for (int i = 0; i < 4; i++) do_req(8'hFF, 8'h00, 0);   // ways 0,1,3,6

    do_reset();
    do_req(8'hF7, 8'h00, 0);                               // free way 3
    do_req(8'hFF, 8'h00, 0);                               // LFSR advanced: way 1

    do_reset();
    do_req(8'hFF, 8'h07, 0);                               // scan to 3, latency 5

    do_reset();
    for (int i = 0; i < 3; i++) do_req(8'hFF, 8'h00, 0);
    do_req(8'hFF, 8'hC0, 0);                               // start 6, wraps to 0
    do_req(8'h00, 8'hFF, 0);                               // all locked

    do_reset();
    do_req(8'hFE, 8'h01, 0);                               // locked-invalid way 0 skipped
    do_req(8'hFF, 8'h00, 5);                               // backpressure

    // Flush while searching; a request in the flush cycle is dropped.
    do_reset();
    do_req(8'hFF, 8'h00, 0);
    req_valid_i = 1'b1; valid_ways_i = 8'hFF; lock_ways_i = 8'h7F;
    step();
    req_valid_i = 1'b0;
    chk("flush_pre_busy", int'(busy_o), 1);
    flush_i = 1'b1; req_valid_i = 1'b1;
    step();
    flush_i = 1'b0; req_valid_i = 1'b0;
    m_lfsr = 0;
    chk("flush_valid", int'(rsp_valid_o), 0);
    chk("flush_busy", int'(busy_o), 0);
    chk("flush_ready", int'(req_ready_o), 1);
    do_req(8'hFF, 8'h00, 0);                               // way 0 after reseed

    // Reset while a response is pending.
    req_valid_i = 1'b1; valid_ways_i = 8'hFF; lock_ways_i = 8'hFF;
    step();
    req_valid_i = 1'b0;
    chk("rstresp_valid", int'(rsp_valid_o), 1);
    do_reset();

    for (int t = 0; t < 300; t++) begin
      logic [7:0] v, l;
      v = 8'($urandom | $urandom);
      l = 8'($urandom & $urandom);
      if ($urandom_range(0, 19) == 0) l = 8'hFF;
      do_req(v, l, int'($urandom_range(0, 3)));
      if ($urandom_range(0, 49) == 0) do_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=%0d exp=%0d", 0, 1);
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end
endmodule
